// File: rtl/vga_timing_gen_if.sv
// Pixel-position / pixel-data bus between the VGA timing generator and the image block.
// The timing generator is the master: it publishes position and strobes, and the image block returns colour.
interface vga_timing_gen_if;
  logic [9:0]  h_count;
  logic [8:0]  v_count;
  logic        pix_en;
  logic        frame_start;
  logic [11:0] color_in;
  logic        active_in;

  modport master (
    output h_count, v_count, pix_en, frame_start,
    input  color_in, active_in
  );

  modport slave (
    input  h_count, v_count, pix_en, frame_start,
    output color_in, active_in
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel divider, h/v counters, PIPE_DLY-matched sync/blank, registered pins.
// Optional VGA_TESTBAR_EN adds a test_en input that replaces image data with 8 vertical colour bars.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_DLY  = 2,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef VGA_TESTBAR_EN
  input  logic             test_en,
`endif
  vga_timing_gen_if.master img,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

`ifdef VGA_TESTBAR_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif

  logic [DIV_W-1:0] div, div_nxt;
  logic             pix_en, frame_start;
  logic [9:0]       h_cnt, v_cnt;
  logic             de, hs_raw, vs_raw;
  logic             de_d, hs_d, vs_d;
  logic [PW-1:0]    raw_vec, dly_vec;
  logic [11:0]      rgb_nxt;

  // pix_en is registered from the next divider value so it stays low while in reset
  assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_nxt;
      pix_en <= (div_nxt == DIV_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign de     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

`ifdef VGA_TESTBAR_EN
  localparam int BAR_PX = H_VISIBLE / 8;
  logic [2:0] bar, bar_d;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (h_cnt >= 10'(k * BAR_PX)) bar = 3'(k);
  end

  assign raw_vec = {bar, vs_raw, hs_raw, de};
  assign bar_d   = dly_vec[5:3];
`else
  assign raw_vec = {vs_raw, hs_raw, de};
`endif

  assign de_d = dly_vec[0];
  assign hs_d = dly_vec[1];
  assign vs_d = dly_vec[2];

  // Cleared stages decode as blank with sync deasserted
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly_vec = raw_vec;
    end else begin : g_dly
      logic [PW-1:0] stage [PIPE_DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DLY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= raw_vec;
          for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
        end
      end
      assign dly_vec = stage[PIPE_DLY-1];
    end
  endgenerate

  always_comb begin
    rgb_nxt = '0;
`ifdef VGA_TESTBAR_EN
    if (test_en) begin
      if (de_d) rgb_nxt = {{4{bar_d[2]}}, {4{bar_d[1]}}, {4{bar_d[0]}}};
    end else
`endif
    if (de_d && img.active_in) rgb_nxt = img.color_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_hs <= hs_d ? SYNC_POL : ~SYNC_POL;
      vga_vs <= vs_d ? SYNC_POL : ~SYNC_POL;
      vga_r  <= rgb_nxt[3:0];
      vga_g  <= rgb_nxt[7:4];
      vga_b  <= rgb_nxt[11:8];
    end
  end

  assign img.h_count     = h_cnt;
  assign img.v_count     = (v_cnt < V_VIS) ? v_cnt[8:0] : 9'h1FF;
  assign img.pix_en      = pix_en;
  assign img.frame_start = frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; horizontal timing at 640x480 defaults, vertical shrunk to 8 lines
// (4 visible, front 1, sync 2, back 1) so whole frames fit in a short run. Covers VGA_TESTBAR_EN when defined.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_en = 1'b0;
  logic vga_hs, vga_vs;
  logic [3:0] vga_r, vga_g, vga_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0, t1, t_rel, t_fs, n;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DLY(2), .SYNC_POL(1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef VGA_TESTBAR_EN
    .test_en(test_en),
`endif
    .img    (bus),
    .vga_hs (vga_hs),
    .vga_vs (vga_vs),
    .vga_r  (vga_r),
    .vga_g  (vga_g),
    .vga_b  (vga_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_h(input int val, input string tag);
    int k = 0;
    while (bus.h_count !== 10'(val) && k < 4000) begin
      tick();
      k++;
    end
    check(tag, 32'(bus.h_count), 32'(val));
  endtask

  initial begin
    bus.color_in  = 12'h000;
    bus.active_in = 1'b0;

    // Reset held with clock running
    repeat (5) tick();
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_rgb", {20'd0, vga_b, vga_g, vga_r}, 32'd0);
    check("rst_h", 32'(bus.h_count), 32'd0);
    check("rst_v", 32'(bus.v_count), 32'd0);
    check("rst_pix_en", 32'(bus.pix_en), 32'd0);
    check("rst_fs", 32'(bus.frame_start), 32'd0);

    // Release: pix_en high after the 3rd edge, first count on the 4th
    rst_n = 1'b1;
    bus.color_in  = 12'hABC;
    bus.active_in = 1'b1;
    tick(); tick();
    check("rel_pix_en_early", 32'(bus.pix_en), 32'd0);
    tick();
    check("rel_pix_en_first", 32'(bus.pix_en), 32'd1);
    check("rel_h0", 32'(bus.h_count), 32'd0);
    check("rel_no_fs", 32'(bus.frame_start), 32'd0);
    tick();
    check("rel_pix_en_one_clk", 32'(bus.pix_en), 32'd0);
    check("rel_h1", 32'(bus.h_count), 32'd1);

    // Line period
    wait_h(799, "wait_h799_a");
    wait_h(0, "wait_h0_a");
    t0 = cyc;
    wait_h(799, "wait_h799_b");
    wait_h(0, "wait_h0_b");
    t1 = cyc;
    check("line_period", 32'(t1 - t0), 32'd3200);
    check("line2_v", 32'(bus.v_count), 32'd2);

    // Colour path in the visible region
    wait_h(100, "wait_h100");
    repeat (4) tick();
    check("color_r", 32'(vga_r), 32'hC);
    check("color_g", 32'(vga_g), 32'hB);
    check("color_b", 32'(vga_b), 32'hA);
    bus.active_in = 1'b0;
    tick();
    check("inactive_rgb", {20'd0, vga_b, vga_g, vga_r}, 32'd0);
    bus.active_in = 1'b1;
    tick();
    check("reactive_r", 32'(vga_r), 32'hC);

    // Blanking edge: last visible pixel still on pins 2 clk after h=640, blank at 3
    wait_h(640, "wait_h640");
    tick(); tick();
    check("blank_edge_pre", 32'(vga_r), 32'hC);
    tick();
    check("blank_edge_post", {20'd0, vga_b, vga_g, vga_r}, 32'd0);

    // hsync: low 3 clk after h=656, for 384 clk
    wait_h(656, "wait_h656");
    t0 = cyc;
    n = 0;
    while (vga_hs !== 1'b0 && n < 50) begin tick(); n++; end
    check("hs_latency", 32'(cyc - t0), 32'd3);
    check("hs_blank_rgb", {20'd0, vga_b, vga_g, vga_r}, 32'd0);
    t0 = cyc;
    n = 0;
    while (vga_hs !== 1'b1 && n < 1000) begin tick(); n++; end
    check("hs_width", 32'(cyc - t0), 32'd384);

    // Async reset mid-line at h=300, v=3
    wait_h(300, "wait_h300");
    check("pre_rst_v", 32'(bus.v_count), 32'd3);
    check("pre_rst_r", 32'(vga_r), 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_h", 32'(bus.h_count), 32'd0);
    check("arst_v", 32'(bus.v_count), 32'd0);
    check("arst_pix_en", 32'(bus.pix_en), 32'd0);
    check("arst_hs_vs", {30'd0, vga_hs, vga_vs}, 32'd3);
    check("arst_rgb", {20'd0, vga_b, vga_g, vga_r}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    t_rel = cyc;
    repeat (4) tick();
    check("restart_h", 32'(bus.h_count), 32'd1);
    check("restart_v", 32'(bus.v_count), 32'd0);

    // Frame timing: 8 lines x 3200 clk
    n = 0;
    while (bus.frame_start !== 1'b1 && n < 30000) begin tick(); n++; end
    t_fs = cyc;
    check("fs_first_delay", 32'(t_fs - t_rel), 32'd25600);
    check("fs_hv", {bus.h_count, 13'd0, bus.v_count}, 32'd0);
    tick();
    check("fs_one_clk", 32'(bus.frame_start), 32'd0);

    n = 0;
    while (bus.v_count !== 9'd3 && n < 20000) begin tick(); n++; end
    check("last_vis_line_time", 32'(cyc - t_fs), 32'd9600);
    n = 0;
    while (bus.v_count === 9'd3 && n < 5000) begin tick(); n++; end
    check("after_vis_time", 32'(cyc - t_fs), 32'd12800);
    check("after_vis_v", 32'(bus.v_count), 32'h1FF);

    n = 0;
    while (vga_vs !== 1'b0 && n < 20000) begin tick(); n++; end
    check("vs_start", 32'(cyc - t_fs), 32'd16003);
    check("vs_v_blank", 32'(bus.v_count), 32'h1FF);
    t0 = cyc;
    n = 0;
    while (vga_vs !== 1'b1 && n < 10000) begin tick(); n++; end
    check("vs_width", 32'(cyc - t0), 32'd6400);

    n = 0;
    while (bus.frame_start !== 1'b1 && n < 30000) begin tick(); n++; end
    check("frame_period", 32'(cyc - t_fs), 32'd25600);

`ifdef VGA_TESTBAR_EN
    test_en = 1'b1;
    bus.active_in = 1'b0;
    wait_h(100, "tb_wait_h100");
    repeat (3) tick();
    check("bar1_red", {20'd0, vga_b, vga_g, vga_r}, 32'h00F);
    wait_h(20, "tb_wait_h20");
    repeat (3) tick();
    check("bar0_black", {20'd0, vga_b, vga_g, vga_r}, 32'h000);
    wait_h(600, "tb_wait_h600");
    repeat (3) tick();
    check("bar7_white", {20'd0, vga_b, vga_g, vga_r}, 32'hFFF);
    test_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
